// File: rtl/dictionary_buffer.sv
// ============================================================================
// Module  : dictionary_buffer
// Purpose : One-entry word pipeline stage plus a FIFO-replacement dictionary.
//           Both feed the per-entry word comparators.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dictionary_buffer #(
   parameter int WORD  = 32,
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [WORD-1:0]       i_word,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [WORD-1:0]       o_word,
   output logic [DEPTH*WORD-1:0] o_dict,
   output logic [DEPTH-1:0]      o_entry_valid,
   output logic [IDX_W:0]        o_count,
   input  logic                  i_upd_en,
   input  logic [WORD-1:0]       i_upd_word,
   output logic [IDX_W-1:0]      o_wr_ptr
);

   localparam logic [IDX_W:0] C_FULL = (IDX_W+1)'(DEPTH);

   logic                 valid_q, valid_d;
   logic [WORD-1:0]      word_q, word_d;
   logic [WORD-1:0]      entry_q [DEPTH];
   logic [DEPTH-1:0]     ent_valid_q, ent_valid_d;
   logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [IDX_W:0]       count_q, count_d;
   logic                 w_accept;
   logic                 w_retire;
   logic                 w_insert;

   assign o_ready  = !i_flush && (!valid_q || i_ready);
   assign w_accept = i_valid && o_ready;
   assign w_retire = valid_q && i_ready;
   // Flush wins over a coincident insert request.
   assign w_insert = i_upd_en && !i_flush;

   always_comb begin
      valid_d     = valid_q;
      word_d      = word_q;
      ent_valid_d = ent_valid_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      if (i_flush) begin
         valid_d     = 1'b0;
         ent_valid_d = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
      end else begin
         if (w_accept) begin
            valid_d = 1'b1;
            word_d  = i_word;
         end else if (w_retire) begin
            valid_d = 1'b0;
         end
         if (w_insert) begin
            ent_valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d              = wr_ptr_q + IDX_W'(1);
            count_d               = (count_q == C_FULL) ? C_FULL : count_q + (IDX_W+1)'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q     <= 1'b0;
         word_q      <= '0;
         ent_valid_q <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            entry_q[k] <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         word_q      <= word_d;
         ent_valid_q <= ent_valid_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         if (w_insert) begin
            entry_q[wr_ptr_q] <= i_upd_word;
         end
      end
   end

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_dict
         assign o_dict[g*WORD +: WORD] = entry_q[g];
      end
   endgenerate

   assign o_valid       = valid_q;
   assign o_word        = word_q;
   assign o_entry_valid = ent_valid_q;
   assign o_count       = count_q;
   assign o_wr_ptr      = wr_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_dictionary_buffer.sv
// ============================================================================
// Module  : tb_dictionary_buffer
// Purpose : Directed self-checking bench for dictionary_buffer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_dictionary_buffer;

   localparam int WORD  = 32;
   localparam int DEPTH = 16;
   localparam int IDX_W = 4;
   localparam int DW    = DEPTH*WORD;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush, in_valid, in_ready, upd_en;
   logic                 out_ready, out_valid;
   logic [WORD-1:0]      in_word, out_word, upd_word;
   logic [DW-1:0]        dict;
   logic [DEPTH-1:0]     ent_valid;
   logic [IDX_W:0]       count;
   logic [IDX_W-1:0]     wr_ptr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dictionary_buffer #(.WORD(WORD), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_flush       (flush),
      .i_valid       (in_valid),
      .o_ready       (out_ready),
      .i_word        (in_word),
      .o_valid       (out_valid),
      .i_ready       (in_ready),
      .o_word        (out_word),
      .o_dict        (dict),
      .o_entry_valid (ent_valid),
      .o_count       (count),
      .i_upd_en      (upd_en),
      .i_upd_word    (upd_word),
      .o_wr_ptr      (wr_ptr)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WORD-1:0] ent(input int k);
      return dict[k*WORD +: WORD];
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
      upd_en = 1'b0; in_word = '0; upd_word = '0;
      #1;
      chk("rst_valid", DW'(out_valid), DW'(0));
      chk("rst_word", DW'(out_word), DW'(0));
      chk("rst_dict", dict, '0);
      chk("rst_entv", DW'(ent_valid), DW'(0));
      chk("rst_count", DW'(count), DW'(0));
      chk("rst_wrptr", DW'(wr_ptr), DW'(0));
      step();
      rst = 1'b0;
      #1;
      chk("idle_ready", DW'(out_ready), DW'(1));

      // Streaming, no bubbles
      in_valid = 1'b1; in_word = 32'h11223344;
      step();
      chk("s0_word", DW'(out_word), DW'(32'h11223344));
      chk("s0_valid", DW'(out_valid), DW'(1));
      in_word = 32'hAABBCCDD;
      step();
      chk("s1_word", DW'(out_word), DW'(32'hAABBCCDD));
      chk("s1_valid", DW'(out_valid), DW'(1));
      in_word = 32'h01020304;
      step();
      chk("s2_word", DW'(out_word), DW'(32'h01020304));
      in_valid = 1'b0;
      step();
      chk("s_drain", DW'(out_valid), DW'(0));

      // Back-pressure
      in_valid = 1'b1; in_word = 32'h11223344;
      step();
      in_ready = 1'b0; in_word = 32'h55667788;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", DW'(out_ready), DW'(0));
         step();
         chk("bp_hold", DW'(out_word), DW'(32'h11223344));
         chk("bp_valid", DW'(out_valid), DW'(1));
      end
      in_ready = 1'b1;
      #1;
      chk("bp_rel_ready", DW'(out_ready), DW'(1));
      step();
      chk("bp_next", DW'(out_word), DW'(32'h55667788));
      chk("bp_next_v", DW'(out_valid), DW'(1));
      in_valid = 1'b0;
      step();
      chk("bp_drain", DW'(out_valid), DW'(0));

      // Fill and wrap
      upd_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         upd_word = 32'(i);
         step();
      end
      chk("fill_count", DW'(count), DW'(16));
      chk("fill_wrptr", DW'(wr_ptr), DW'(0));
      chk("fill_entv", DW'(ent_valid), DW'(16'hFFFF));
      chk("fill_e0", DW'(ent(0)), DW'(32'h1));
      chk("fill_e15", DW'(ent(15)), DW'(32'h10));
      upd_word = 32'h11;
      step();
      upd_en = 1'b0;
      chk("wrap_e0", DW'(ent(0)), DW'(32'h11));
      chk("wrap_e1", DW'(ent(1)), DW'(32'h2));
      chk("wrap_wrptr", DW'(wr_ptr), DW'(1));
      chk("wrap_count", DW'(count), DW'(16));

      // Flush priority
      in_valid = 1'b1; in_word = 32'h0BADF00D;
      step();
      chk("fl_pre_valid", DW'(out_valid), DW'(1));
      flush = 1'b1; upd_en = 1'b1; upd_word = 32'h99999999; in_word = 32'h12345678;
      #1;
      chk("fl_ready", DW'(out_ready), DW'(0));
      step();
      flush = 1'b0; upd_en = 1'b0; in_valid = 1'b0;
      chk("fl_entv", DW'(ent_valid), DW'(0));
      chk("fl_count", DW'(count), DW'(0));
      chk("fl_wrptr", DW'(wr_ptr), DW'(0));
      chk("fl_valid", DW'(out_valid), DW'(0));
      chk("fl_no_ins", DW'(ent(1)), DW'(32'h2));
      chk("fl_keep_e0", DW'(ent(0)), DW'(32'h11));

      // Update/compare ordering
      in_valid = 1'b1; in_word = 32'hDEADBEEF;
      step();
      upd_en = 1'b1; upd_word = 32'hDEADBEEF;
      step();
      upd_en = 1'b0; in_valid = 1'b0;
      chk("uc_valid", DW'(out_valid), DW'(1));
      chk("uc_word", DW'(out_word), DW'(32'hDEADBEEF));
      chk("uc_e0", DW'(ent(0)), DW'(32'hDEADBEEF));
      chk("uc_entv", DW'(ent_valid), DW'(16'h0001));
      chk("uc_count", DW'(count), DW'(1));
      chk("uc_wrptr", DW'(wr_ptr), DW'(1));

      // Asynchronous reset mid-stream
      in_valid = 1'b1; in_word = 32'hCAFEF00D; in_ready = 1'b0;
      step();
      chk("ar_pre_valid", DW'(out_valid), DW'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", DW'(out_valid), DW'(0));
      chk("ar_count", DW'(count), DW'(0));
      chk("ar_entv", DW'(ent_valid), DW'(0));
      chk("ar_wrptr", DW'(wr_ptr), DW'(0));
      in_valid = 1'b0; in_ready = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      chk("ar_ready", DW'(out_ready), DW'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
